// File: rtl/cmat_codebook_mult.sv
// cmat_codebook_mult
// Buffers one complex channel matrix H (ROWS x K) and multiplies it by a
// run-time number of codeword matrices S_q (K x COLS). Codeword entries are
// drawn from {+0.5, -0.5, +0.5j, -0.5j}, selected by a 2-bit code table, so
// each product term is just a swap and/or negation of H. One term is added
// per cycle. Each finished element is rounded half-up and saturated to N bits,
// then presented on a valid/ready output with its (q, row, col) position tags.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    begin a run (sampled in IDLE) / return to IDLE at once
//   num_q           codewords per run (0 or above NUM_CW means NUM_CW)
//   cb_table        code (q,k,j) at bits [2*((q*K+k)*COLS+j) +: 2]
//   h_valid/h_ready H sample handshake, samples row-major in h_in_r/h_in_i
//   out_valid/out_ready  result handshake, result in out_r/out_i
//   out_q/out_row/out_col position tags of the presented result
//   out_mat_last    last element of one codeword's matrix
//   out_last        last element of the run
//   busy, done      not idle / one-cycle end-of-run pulse
//   sat_flag        sticky: some result of this run was clamped
module cmat_codebook_mult #(
  parameter int N           = 16,
  parameter int ROWS        = 4,
  parameter int K           = 4,
  parameter int COLS        = 2,
  parameter int NUM_CW      = 16,
  parameter int ACC_W       = 32,
  parameter int SCALE_SHIFT = 1,
  localparam int QW = (NUM_CW > 1) ? $clog2(NUM_CW) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [QW:0]                  num_q,
  input  logic [NUM_CW*K*COLS*2-1:0]   cb_table,
  input  logic                         h_valid,
  output logic                         h_ready,
  input  logic [N-1:0]                 h_in_r,
  input  logic [N-1:0]                 h_in_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 out_r,
  output logic [N-1:0]                 out_i,
  output logic [QW-1:0]                out_q,
  output logic [RW-1:0]                out_row,
  output logic [CW-1:0]                out_col,
  output logic                         out_mat_last,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);

  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int NCODES = NUM_CW * K * COLS;
  localparam int CBW    = (NCODES > 1) ? $clog2(NCODES) : 1;

  localparam logic [KW-1:0] K_LAST    = KW'(K - 1);
  localparam logic [RW-1:0] R_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(COLS - 1);
  localparam logic [QW:0]   NUMQ_MAX  = (QW + 1)'(NUM_CW);
  localparam logic [QW:0]   NUMQ_ONE  = (QW + 1)'(1);

  // Half an LSB of the shifted result; collapses to zero when nothing is shifted.
  localparam logic signed [ACC_W-1:0] RND  = (ACC_W'(1) << SCALE_SHIFT) >> 1;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

  typedef enum logic [2:0] {IDLE, LOAD, ACC, OUT, DONE} state_t;

  state_t state_q, state_d;

  logic [QW:0]   nq_lat;
  logic [RW-1:0] ld_row, i_cnt;
  logic [KW-1:0] ld_col, k_cnt;
  logic [CW-1:0] j_cnt;
  logic [QW-1:0] q_cnt;

  logic [N-1:0] buf_r [ROWS][K];
  logic [N-1:0] buf_i [ROWS][K];

  logic [1:0]     code_arr [NCODES];
  logic [CBW-1:0] cb_sel;
  logic [1:0]     code;

  logic signed [ACC_W-1:0] hr_x, hi_x, term_r, term_i, sum_r, sum_i;
  logic signed [ACC_W-1:0] acc_r, acc_i;
  logic [N:0]              res_r, res_i;
  logic                    elem_mat_last, q_is_last;

  // Scale, round half up and clamp; the top bit reports that clamping happened.
  function automatic logic [N:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
    v = (a + RND) >>> SCALE_SHIFT;
    if (v > MAXV)
      round_sat = {1'b1, MAXV[N-1:0]};
    else if (v < MINV)
      round_sat = {1'b1, MINV[N-1:0]};
    else
      round_sat = {1'b0, v[N-1:0]};
  endfunction

  // Unpack the flat code table into an addressable array of 2-bit codes.
  for (genvar e = 0; e < NCODES; e++) begin : g_codes
    assign code_arr[e] = cb_table[2*e +: 2];
  end

  assign h_ready   = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Select the current code and H entry and form this cycle's term.
  // The codeword entries are all magnitude 0.5, so the term is +-H or +-jH
  // and the 0.5 is applied later as a rounded shift.
  always_comb begin
    cb_sel = CBW'(((int'(q_cnt) * K) + int'(k_cnt)) * COLS + int'(j_cnt));
    code   = code_arr[cb_sel];
    hr_x   = ACC_W'($signed(buf_r[i_cnt][k_cnt]));
    hi_x   = ACC_W'($signed(buf_i[i_cnt][k_cnt]));
    case (code)
      2'b00:   begin term_r = hr_x;  term_i = hi_x;  end
      2'b01:   begin term_r = -hr_x; term_i = -hi_x; end
      2'b10:   begin term_r = -hi_x; term_i = hr_x;  end
      default: begin term_r = hi_x;  term_i = -hr_x; end
    endcase
    sum_r = ((k_cnt == '0) ? ACC_ZERO : acc_r) + term_r;
    sum_i = ((k_cnt == '0) ? ACC_ZERO : acc_i) + term_i;
    res_r = round_sat(sum_r);
    res_i = round_sat(sum_i);
    elem_mat_last = (i_cnt == R_LAST) && (j_cnt == C_LAST);
    q_is_last     = ((QW + 1)'(q_cnt) == (nq_lat - NUMQ_ONE));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (h_valid && ld_row == R_LAST && ld_col == K_LAST) state_d = ACC;
      ACC:  if (k_cnt == K_LAST) state_d = OUT;
      OUT:  if (out_ready) state_d = out_last ? DONE : ACC;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort)
      state_d = IDLE;
  end

  // Counters, accumulators, registered results and the sticky saturation flag.
  // Tags are captured together with the result so they stay aligned while the
  // output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nq_lat       <= '0;
      ld_row       <= '0;
      ld_col       <= '0;
      q_cnt        <= '0;
      i_cnt        <= '0;
      j_cnt        <= '0;
      k_cnt        <= '0;
      acc_r        <= '0;
      acc_i        <= '0;
      out_r        <= '0;
      out_i        <= '0;
      out_q        <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_mat_last <= 1'b0;
      out_last     <= 1'b0;
      sat_flag     <= 1'b0;
    end else if (!abort) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sat_flag <= 1'b0;
            nq_lat   <= (num_q == '0 || num_q > NUMQ_MAX) ? NUMQ_MAX : num_q;
            ld_row   <= '0;
            ld_col   <= '0;
            q_cnt    <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
          end
        end
        LOAD: begin
          if (h_valid) begin
            if (ld_col == K_LAST) begin
              ld_col <= '0;
              ld_row <= (ld_row == R_LAST) ? '0 : ld_row + RW'(1);
            end else begin
              ld_col <= ld_col + KW'(1);
            end
          end
        end
        ACC: begin
          acc_r <= sum_r;
          acc_i <= sum_i;
          if (k_cnt == K_LAST) begin
            k_cnt        <= '0;
            out_r        <= res_r[N-1:0];
            out_i        <= res_i[N-1:0];
            sat_flag     <= sat_flag | res_r[N] | res_i[N];
            out_q        <= q_cnt;
            out_row      <= i_cnt;
            out_col      <= j_cnt;
            out_mat_last <= elem_mat_last;
            out_last     <= elem_mat_last && q_is_last;
          end else begin
            k_cnt <= k_cnt + KW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            if (j_cnt == C_LAST) begin
              j_cnt <= '0;
              if (i_cnt == R_LAST) begin
                i_cnt <= '0;
                q_cnt <= q_cnt + QW'(1);
              end else begin
                i_cnt <= i_cnt + RW'(1);
              end
            end else begin
              j_cnt <= j_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // H buffer; deliberately not reset, every run reloads it completely.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && h_valid && !abort) begin
      buf_r[ld_row][ld_col] <= h_in_r;
      buf_i[ld_row][ld_col] <= h_in_i;
    end
  end

endmodule
